combination_lock_input_conditioner: RTL and testbench

COMBINATION_LOCK_INPUT_CONDITIONER -- requirements
Module: combination_lock_input_conditioner

---
 rtl/combination_lock_pkg.sv | 19 +
 rtl/button_debouncer.sv | 82 ++++++++
 rtl/combination_lock_input_conditioner.sv | 74 +++++++
 tb/tb_combination_lock_input_conditioner.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/combination_lock_pkg.sv
// Shared definitions for the combination lock input conditioner:
// debounce FSM state encoding, default qualification time and counter sizing.
package combination_lock_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 20000;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } debounce_state_t;

    // Width of a counter that must reach cycles-1; never narrower than one bit.
    function automatic int counter_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button channel: two-flop synchronizer, press/release qualification
// FSM with a saturating counter, and a gated single-cycle press pulse.
module button_debouncer
    import combination_lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic pulse_enable,
    output logic pulse
);

    localparam int CW = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_MAX  = '1;

    logic [1:0]      sync_ff;
    logic            level;
    logic [CW-1:0]   count;
    debounce_state_t state;

    assign level = sync_ff[1];

    // Bring the bouncing asynchronous button into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], raw};
        end
    end

    // Qualify presses and releases; the pulse fires on the qualifying edge only when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RELEASED;
            count <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                RELEASED: begin
                    if (level) begin
                        state <= PRESS_WAIT;
                        count <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!level) begin
                        state <= RELEASED;
                    end else if (count == COUNT_LAST) begin
                        state <= PRESSED;
                        pulse <= pulse_enable;
                    end else if (count != COUNT_MAX) begin
                        count <= count + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!level) begin
                        state <= RELEASE_WAIT;
                        count <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (level) begin
                        state <= PRESSED;
                    end else if (count == COUNT_LAST) begin
                        state <= RELEASED;
                    end else if (count != COUNT_MAX) begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                end
            endcase
        end
    end

endmodule

// File: rtl/combination_lock_input_conditioner.sv
// Conditions the raw lock front panel: two debounced one-pulse buttons and a
// debounced 4-bit password, with key pulses suppressed while switches are unsettled.
module combination_lock_input_conditioner
    import combination_lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Btn1Raw,
    input  logic       Btn2Raw,
    input  logic [3:0] SwRaw,
    output logic       Key1,
    output logic       Key2,
    output logic [3:0] Password,
    output logic       PwStable
);

    localparam int CW = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_MAX  = '1;

    logic [3:0]    sw_sync1;
    logic [3:0]    sw_sync2;
    logic [3:0]    candidate;
    logic [CW-1:0] pw_count;

    // A key press only counts when the switches already match the accepted password.
    assign PwStable = (sw_sync2 == Password);

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) btn1 (
        .clk          (Clk),
        .reset        (Reset),
        .raw          (Btn1Raw),
        .pulse_enable (PwStable),
        .pulse        (Key1)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) btn2 (
        .clk          (Clk),
        .reset        (Reset),
        .raw          (Btn2Raw),
        .pulse_enable (PwStable),
        .pulse        (Key2)
    );

    // Bring the slide switches into the clock domain.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sw_sync1 <= 4'b0000;
            sw_sync2 <= 4'b0000;
        end else begin
            sw_sync1 <= SwRaw;
            sw_sync2 <= sw_sync1;
        end
    end

    // Track the current switch value and accept it once it has held long enough.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            candidate <= 4'b0000;
            pw_count  <= '0;
            Password  <= 4'b0000;
        end else if (sw_sync2 != candidate) begin
            candidate <= sw_sync2;
            pw_count  <= '0;
        end else if (pw_count == COUNT_LAST) begin
            Password <= candidate;
        end else if (pw_count != COUNT_MAX) begin
            pw_count <= pw_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_combination_lock_input_conditioner.sv
// Self-checking bench for the combination lock input conditioner with a short
// debounce time: directed table, multi-cycle corner sequences and random stimulus
// compared every cycle against a run-length reference model.
module tb_combination_lock_input_conditioner;

    localparam int DEB = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Btn1Raw;
    logic       Btn2Raw;
    logic [3:0] SwRaw;
    logic       Key1;
    logic       Key2;
    logic [3:0] Password;
    logic       PwStable;

    int checks = 0;
    int passes = 0;
    bit checkEn = 1'b0;

    // Reference model state: raw samples of the last two edges, debounced levels with
    // the length of the current disagreeing run, and the accepted password.
    bit         m_b1_hist[$];
    bit         m_b2_hist[$];
    logic [3:0] m_sw_hist[$];
    bit         m_level[2];
    int         m_run[2];
    bit         m_key[2];
    logic [3:0] m_pw;
    logic [3:0] m_last_seen;
    int         m_sw_run;

    typedef struct {
        logic       b1;
        logic       b2;
        logic [3:0] sw;
        int         cycles;
        int         exp_k1;
        int         exp_k2;
        logic [3:0] exp_pw;
    } vec_t;

    vec_t vecs[10];

    combination_lock_input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Btn1Raw  (Btn1Raw),
        .Btn2Raw  (Btn2Raw),
        .SwRaw    (SwRaw),
        .Key1     (Key1),
        .Key2     (Key2),
        .Password (Password),
        .PwStable (PwStable)
    );

    // Free-running system clock.
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Advance the model by one rising edge using the values the DUT samples there.
    function automatic void modelStep();
        logic [3:0] sw_seen;
        bit         stable_before;
        bit         seen[2];
        bit         ev;
        if (Reset) begin
            m_b1_hist.delete(); m_b1_hist.push_back(1'b0); m_b1_hist.push_back(1'b0);
            m_b2_hist.delete(); m_b2_hist.push_back(1'b0); m_b2_hist.push_back(1'b0);
            m_sw_hist.delete(); m_sw_hist.push_back(4'h0); m_sw_hist.push_back(4'h0);
            for (int b = 0; b < 2; b++) begin
                m_level[b] = 1'b0;
                m_run[b]   = 0;
                m_key[b]   = 1'b0;
            end
            m_pw        = 4'h0;
            m_last_seen = 4'h0;
            m_sw_run    = 1;
            return;
        end
        sw_seen       = m_sw_hist[0];
        stable_before = (sw_seen == m_pw);
        seen[0]       = m_b1_hist[0];
        seen[1]       = m_b2_hist[0];
        for (int b = 0; b < 2; b++) begin
            ev = 1'b0;
            if (seen[b] == m_level[b]) begin
                m_run[b] = 0;
            end else begin
                m_run[b]++;
                if (m_run[b] == DEB + 1) begin
                    m_level[b] = seen[b];
                    m_run[b]   = 0;
                    ev         = seen[b];
                end
            end
            m_key[b] = ev && stable_before;
        end
        if (sw_seen == m_last_seen) begin
            if (m_sw_run < DEB + 1) m_sw_run++;
        end else begin
            m_sw_run = 1;
        end
        m_last_seen = sw_seen;
        if (m_sw_run >= DEB + 1) m_pw = sw_seen;
        m_b1_hist.push_back(Btn1Raw); void'(m_b1_hist.pop_front());
        m_b2_hist.push_back(Btn2Raw); void'(m_b2_hist.pop_front());
        m_sw_hist.push_back(SwRaw);   void'(m_sw_hist.pop_front());
    endfunction

    // Keep the reference model in lockstep with the DUT clock.
    always @(posedge Clk) modelStep();

    // Compare every output against the model on the falling edge.
    always @(negedge Clk) begin
        if (checkEn) begin
            checkOutput("model_key1", Key1, m_key[0]);
            checkOutput("model_key2", Key2, m_key[1]);
            checkOutput("model_password", Password, m_pw);
            checkOutput("model_pwstable", PwStable, (m_sw_hist[0] == m_pw));
        end
    end

    task automatic applyStimulus(input logic b1, input logic b2, input logic [3:0] sw);
        Btn1Raw = b1;
        Btn2Raw = b2;
        SwRaw   = sw;
    endtask

    // Run n edges, recording the first edge index and number of pulses on each key.
    task automatic runCycles(input int n, output int first1, output int cnt1, output int first2, output int cnt2);
        first1 = -1; cnt1 = 0; first2 = -1; cnt2 = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Key1 === 1'b1) begin
                if (first1 < 0) first1 = i;
                cnt1++;
            end
            if (Key2 === 1'b1) begin
                if (first2 < 0) first2 = i;
                cnt2++;
            end
        end
    endtask

    initial begin
        int f1, c1, f2, c2;
        int acc1, acc2;

        vecs[0] = '{1'b0, 1'b0, 4'h0, 10, 0, 0, 4'h0};
        vecs[1] = '{1'b1, 1'b0, 4'h0, 20, 1, 0, 4'h0};
        vecs[2] = '{1'b0, 1'b0, 4'h0, 10, 0, 0, 4'h0};
        vecs[3] = '{1'b0, 1'b0, 4'hD, 10, 0, 0, 4'hD};
        vecs[4] = '{1'b1, 1'b1, 4'hD, 12, 1, 1, 4'hD};
        vecs[5] = '{1'b0, 1'b0, 4'hD, 10, 0, 0, 4'hD};
        vecs[6] = '{1'b0, 1'b1, 4'h6, 12, 0, 0, 4'h6};
        vecs[7] = '{1'b0, 1'b0, 4'h6, 10, 0, 0, 4'h6};
        vecs[8] = '{1'b0, 1'b1, 4'h6, 10, 0, 1, 4'h6};
        vecs[9] = '{1'b0, 1'b0, 4'h6, 10, 0, 0, 4'h6};

        Reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0);
        @(negedge Clk);
        @(negedge Clk);
        Reset   = 1'b0;
        checkEn = 1'b1;
        checkOutput("reset_key1", Key1, 1'b0);
        checkOutput("reset_key2", Key2, 1'b0);
        checkOutput("reset_password", Password, 4'h0);
        checkOutput("reset_pwstable", PwStable, 1'b1);

        $display("[TB] directed table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].b1, vecs[i].b2, vecs[i].sw);
            runCycles(vecs[i].cycles, f1, c1, f2, c2);
            checkOutput($sformatf("vec%0d_key1_count", i), c1, vecs[i].exp_k1);
            checkOutput($sformatf("vec%0d_key2_count", i), c2, vecs[i].exp_k2);
            checkOutput($sformatf("vec%0d_password", i), Password, vecs[i].exp_pw);
        end

        $display("[TB] button 1 latency");
        applyStimulus(1'b1, 1'b0, 4'h6);
        runCycles(20, f1, c1, f2, c2);
        checkOutput("b1_latency", f1, DEB + 2);
        checkOutput("b1_single_pulse", c1, 1);
        checkOutput("b1_no_key2", c2, 0);
        applyStimulus(1'b0, 1'b0, 4'h6);
        runCycles(10, f1, c1, f2, c2);
        checkOutput("b1_release_no_pulse", c1, 0);

        $display("[TB] button 2 bounce");
        acc2 = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, 4'h6);
            runCycles(1, f1, c1, f2, c2);
            acc2 += c2;
        end
        applyStimulus(1'b0, 1'b1, 4'h6);
        runCycles(16, f1, c1, f2, c2);
        checkOutput("b2_bounce_no_early", acc2, 0);
        checkOutput("b2_latency_after_last_rise", f2, DEB + 2);
        checkOutput("b2_single_pulse", c2, 1);
        applyStimulus(1'b0, 1'b0, 4'h6);
        runCycles(10, f1, c1, f2, c2);

        $display("[TB] simultaneous buttons");
        applyStimulus(1'b1, 1'b1, 4'h6);
        runCycles(14, f1, c1, f2, c2);
        checkOutput("both_key1_edge", f1, DEB + 2);
        checkOutput("both_key2_edge", f2, DEB + 2);
        checkOutput("both_key1_count", c1, 1);
        checkOutput("both_key2_count", c2, 1);
        applyStimulus(1'b0, 1'b0, 4'h6);
        runCycles(10, f1, c1, f2, c2);
        checkOutput("both_release_key1", c1, 0);
        checkOutput("both_release_key2", c2, 0);

        $display("[TB] password settle");
        applyStimulus(1'b0, 1'b0, 4'h0);
        runCycles(10, f1, c1, f2, c2);
        applyStimulus(1'b0, 1'b0, 4'hD);
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (i == 3) checkOutput("pw_unstable_between", PwStable, 1'b0);
            if (i == 5) checkOutput("pw_old_before_accept", Password, 4'h0);
            if (i == 6) checkOutput("pw_accepted", Password, 4'hD);
        end
        applyStimulus(1'b1, 1'b0, 4'hD);
        runCycles(12, f1, c1, f2, c2);
        checkOutput("pw_then_key1_edge", f1, DEB + 2);
        checkOutput("pw_then_key1_count", c1, 1);
        applyStimulus(1'b0, 1'b0, 4'hD);
        runCycles(10, f1, c1, f2, c2);

        $display("[TB] switch chatter during press");
        acc1 = 0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, 1'b0, (i % 2 == 0) ? 4'h0 : 4'hF);
            runCycles(1, f1, c1, f2, c2);
            acc1 += c1;
        end
        checkOutput("chatter_password_held", Password, 4'hD);
        applyStimulus(1'b1, 1'b0, 4'hD);
        runCycles(10, f1, c1, f2, c2);
        acc1 += c1;
        checkOutput("chatter_key1_dropped", acc1, 0);
        checkOutput("chatter_password_final", Password, 4'hD);
        applyStimulus(1'b0, 1'b0, 4'hD);
        runCycles(10, f1, c1, f2, c2);

        $display("[TB] reset during qualification");
        applyStimulus(1'b0, 1'b0, 4'h0);
        runCycles(10, f1, c1, f2, c2);
        applyStimulus(1'b1, 1'b0, 4'h0);
        runCycles(3, f1, c1, f2, c2);
        acc1 = c1;
        Reset = 1'b1;
        runCycles(1, f1, c1, f2, c2);
        acc1 += c1;
        checkOutput("reset_mid_key1_low", Key1, 1'b0);
        Reset = 1'b0;
        runCycles(12, f1, c1, f2, c2);
        checkOutput("reset_no_early_pulse", acc1, 0);
        checkOutput("reset_held_latency", f1, DEB + 2);
        checkOutput("reset_held_count", c1, 1);
        applyStimulus(1'b0, 1'b0, 4'h0);
        runCycles(10, f1, c1, f2, c2);

        $display("[TB] random stimulus");
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) Btn1Raw = ~Btn1Raw;
            if ($urandom_range(0, 7) == 0) Btn2Raw = ~Btn2Raw;
            if ($urandom_range(0, 19) == 0) SwRaw = 4'($urandom_range(0, 15));
            Reset = ($urandom_range(0, 299) == 0);
            @(posedge Clk);
            @(negedge Clk);
        end
        Reset = 1'b0;
        runCycles(4, f1, c1, f2, c2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
